// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier: one multiplier bit per clock, WIDTH steps per product.
// Results are committed to prod only on completion, with a one-cycle done pulse.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               write,
  input  logic               reset,
  input  logic [WIDTH-1:0]   mul,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy,
  output logic               done
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic            step_s;
  logic [PW-1:0]   acc_r;
  logic [PW-1:0]   mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [CW-1:0]   cnt_r;
  logic [PW-1:0]   prod_r;
  logic            busy_r;
  logic            done_r;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a write edge restarts from any state, aborting a RUN.
  always_comb begin
    next_state_s = state_r;
    step_s       = 1'b0;
    if (write) begin
      next_state_s = RUN;
    end else begin
      case (state_r)
        IDLE: next_state_s = IDLE;
        RUN: begin
          step_s = 1'b1;
          if (cnt_r == LAST_CNT) begin
            next_state_s = DONE;
          end else begin
            next_state_s = RUN;
          end
        end
        DONE:    next_state_s = IDLE;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // Operand capture and iteration; multiplicand shifts left as multiplier shifts right.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r    <= {PW{1'b0}};
      mcand_r  <= {PW{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (write) begin
      acc_r    <= {PW{1'b0}};
      mcand_r  <= {{WIDTH{1'b0}}, mul};
      mplier_r <= b;
      cnt_r    <= {CW{1'b0}};
    end else if (step_s) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CNT_ONE;
    end
  end

  // Registered outputs; prod only ever takes a finished accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_r <= {PW{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s == RUN);
      done_r <= (state_r == DONE);
      if (state_r == DONE) begin
        prod_r <= acc_r;
      end
    end
  end

  assign prod = prod_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: two parallel instances, hand-computed products.
module tb_seq_multiplier;

  logic        clk;
  logic        reset;
  logic        w0, w1;
  logic [7:0]  mul0, b0, mul1, b1;
  logic [15:0] prod0, prod1;
  logic        busy0, busy1, done0, done1;
  int          total;
  int          passed;

  seq_multiplier #(.WIDTH(8)) u0 (
    .clk(clk), .write(w0), .reset(reset), .mul(mul0), .b(b0),
    .prod(prod0), .busy(busy0), .done(done0)
  );

  seq_multiplier #(.WIDTH(8)) u1 (
    .clk(clk), .write(w1), .reset(reset), .mul(mul1), .b(b1),
    .prod(prod1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  // Issue a one-edge write on u0; returns just after the write edge.
  task automatic load0(input logic [7:0] m, input logic [7:0] bb);
    @(negedge clk);
    w0 = 1'b1; mul0 = m; b0 = bb;
    @(negedge clk);
    w0 = 1'b0;
  endtask

  // Called just after write edge N: done must appear exactly after edge N+9.
  task automatic expect_result(input string tag, input logic [15:0] exp, input logic [15:0] prev);
    chk1({tag, "_busy_start"}, busy0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk1({tag, "_no_done"}, done0, 1'b0);
      chk1({tag, "_busy"}, busy0, (i < 8));
      chk16({tag, "_prod_hold"}, prod0, prev);
    end
    @(negedge clk);
    chk1({tag, "_done"}, done0, 1'b1);
    chk16({tag, "_prod"}, prod0, exp);
    @(negedge clk);
    chk1({tag, "_done_drop"}, done0, 1'b0);
    chk16({tag, "_prod_keep"}, prod0, exp);
  endtask

  initial begin
    total = 0; passed = 0;
    reset = 1'b0; w0 = 1'b0; w1 = 1'b0;
    mul0 = 8'd0; b0 = 8'd0; mul1 = 8'd0; b1 = 8'd0;
    #2;
    chk16("rst_prod", prod0, 16'h0000);
    chk1("rst_busy", busy0, 1'b0);
    chk1("rst_done", done0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // 8x7 and 10x11 in parallel, same timing
    @(negedge clk);
    w0 = 1'b1; mul0 = 8'd8;  b0 = 8'd7;
    w1 = 1'b1; mul1 = 8'd10; b1 = 8'd11;
    @(negedge clk);
    w0 = 1'b0; w1 = 1'b0;
    chk1("par_busy0", busy0, 1'b1);
    chk1("par_busy1", busy1, 1'b1);
    repeat (7) @(negedge clk);
    chk1("par_busy_last", busy0, 1'b1);
    chk16("par_no_partial", prod0, 16'h0000);
    @(negedge clk);
    chk1("par_busy_off", busy0, 1'b0);
    chk1("par_done_early", done0, 1'b0);
    @(negedge clk);
    chk1("par_done0", done0, 1'b1);
    chk1("par_done1", done1, 1'b1);
    chk16("par_prod0", prod0, 16'h0038);
    chk16("par_prod1", prod1, 16'h006E);
    @(negedge clk);
    chk1("par_done0_drop", done0, 1'b0);
    chk1("par_done1_drop", done1, 1'b0);

    load0(8'd255, 8'd255);
    expect_result("max", 16'hFE01, 16'h0038);

    load0(8'd0, 8'd200);
    expect_result("zero", 16'h0000, 16'hFE01);

    // write held for two edges, operands change between them
    @(negedge clk);
    w0 = 1'b1; mul0 = 8'd3; b0 = 8'd4;
    @(negedge clk);
    mul0 = 8'd5; b0 = 8'd6;
    @(negedge clk);
    w0 = 1'b0;
    expect_result("hold", 16'd30, 16'h0000);

    // abort 8x7 after three steps with 9x9; operand changes during RUN are ignored
    load0(8'd8, 8'd7);
    repeat (3) @(negedge clk);
    chk1("abort_no_done", done0, 1'b0);
    w0 = 1'b1; mul0 = 8'd9; b0 = 8'd9;
    @(negedge clk);
    w0 = 1'b0; mul0 = 8'd77; b0 = 8'd200;
    expect_result("abort", 16'd81, 16'd30);

    // asynchronous reset mid-RUN
    load0(8'd255, 8'd255);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk16("arst_prod0", prod0, 16'h0000);
    chk16("arst_prod1", prod1, 16'h0000);
    chk1("arst_busy", busy0, 1'b0);
    chk1("arst_done", done0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk16("post_rst_prod", prod0, 16'h0000);
    chk1("post_rst_busy", busy0, 1'b0);
    chk1("post_rst_done", done0, 1'b0);

    // write on the very first edge after reset release
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; w0 = 1'b1; mul0 = 8'd12; b0 = 8'd13;
    @(negedge clk);
    w0 = 1'b0;
    expect_result("rel_write", 16'd156, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
